// File: rtl/fma_dot_sequencer.sv
// Dot-product control stage for dualFMA; `define FMA_SEQ_PERF_EN adds the perf_cycles busy counter.
// FMA_LAT+1 cycles per element; stalls in ISSUE while in_valid is low, holds the result until out_ready.
module fma_dot_sequencer #(
  parameter int FMA_LAT = 3,
  parameter int LEN_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             mode,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_act,
  input  logic [7:0]       in_w,
  output logic [15:0]      fma_act,
  output logic [7:0]       fma_in,
  output logic             fma_mode,
  output logic [15:0]      fma_acc1,
  output logic [15:0]      fma_acc2,
  input  logic [15:0]      fma_acc1_out,
  input  logic [15:0]      fma_acc2_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_acc1,
  output logic [15:0]      out_acc2
`ifdef FMA_SEQ_PERF_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  localparam int WCNT_W = (FMA_LAT > 1) ? $clog2(FMA_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FMA_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [15:0]       acc1_q;
  logic [15:0]       acc2_q;
  logic [LEN_W-1:0]  remaining_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              mode_q;

  logic job_start;
  logic fire;
  logic capture;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fma_act   = 16'h0000;
    fma_in    = 8'h00;
    job_start = 1'b0;
    fire      = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          job_start = 1'b1;
          state_d   = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        in_ready = 1'b1;
        fma_act  = in_act;
        fma_in   = in_w;
        if (in_valid) begin
          fire    = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // dualFMA output for the issued element is visible on this cycle
        if (wcnt_q == WCNT_LAST) begin
          capture = 1'b1;
          state_d = (remaining_q == LEN_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc1_q      <= 16'h0000;
      acc2_q      <= 16'h0000;
      remaining_q <= '0;
      wcnt_q      <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (job_start) begin
        mode_q      <= mode;
        acc1_q      <= 16'h0000;
        acc2_q      <= 16'h0000;
        remaining_q <= len;
      end
      if (fire) begin
        wcnt_q <= '0;
      end else if (state_q == WAIT) begin
        wcnt_q <= wcnt_q + WCNT_W'(1);
      end
      if (capture) begin
        acc1_q      <= fma_acc1_out;
        acc2_q      <= fma_acc2_out;
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

`ifdef FMA_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles <= 32'h0;
    end else if (job_start) begin
      perf_cycles <= 32'h0;
    end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

  assign busy     = (state_q != IDLE);
  assign fma_mode = mode_q;
  assign fma_acc1 = acc1_q;
  assign fma_acc2 = acc2_q;
  // acc1 lane carries nothing meaningful for int8 weights
  assign out_acc1 = mode_q ? acc1_q : 16'h0000;
  assign out_acc2 = acc2_q;

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench for fma_dot_sequencer with a behavioural dualFMA (FMA_LAT register stages).
module tb_fma_dot_sequencer;
  localparam int FMA_LAT = 3;
  localparam int LEN_W   = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             mode;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_act;
  logic [7:0]       in_w;
  logic [15:0]      fma_act;
  logic [7:0]       fma_in;
  logic             fma_mode;
  logic [15:0]      fma_acc1;
  logic [15:0]      fma_acc2;
  logic [15:0]      fma_acc1_out;
  logic [15:0]      fma_acc2_out;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_acc1;
  logic [15:0]      out_acc2;
`ifdef FMA_SEQ_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fma_dot_sequencer #(.FMA_LAT(FMA_LAT), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .mode(mode), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_w(in_w),
    .fma_act(fma_act), .fma_in(fma_in), .fma_mode(fma_mode),
    .fma_acc1(fma_acc1), .fma_acc2(fma_acc2),
    .fma_acc1_out(fma_acc1_out), .fma_acc2_out(fma_acc2_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc1(out_acc1), .out_acc2(out_acc2)
`ifdef FMA_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  function automatic real pow2(input int e);
    real r = 1.0;
    for (int i = 0; i < e; i++) r = r * 2.0;
    for (int i = 0; i > e; i--) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e;
    real r;
    e = int'(h[14:10]);
    if (e == 0) r = (real'(h[9:0]) / 1024.0) * pow2(-14);
    else        r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    logic s;
    real  a;
    int   e;
    int   m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    return {s, e[4:0], m[9:0]};
  endfunction

  function automatic real f4(input logic [3:0] q);
    real v;
    if (q[2:1] == 2'b00) v = real'(q[0]) * 0.5;
    else                 v = (1.0 + real'(q[0]) * 0.5) * pow2(int'(q[2:1]) - 1);
    return q[3] ? -v : v;
  endfunction

  function automatic real i8(input logic [7:0] w);
    return real'(int'($signed(w)));
  endfunction

  // dualFMA model; in mode 0 the acc1 lane accumulates raw act as junk so output masking is observable
  function automatic logic [15:0] lane1(input logic md, input logic [15:0] a, input logic [7:0] w,
                                        input logic [15:0] acc);
    if (md) return r2h(h2r(acc) + h2r(a) * f4(w[7:4]));
    return r2h(h2r(acc) + h2r(a));
  endfunction

  function automatic logic [15:0] lane2(input logic md, input logic [15:0] a, input logic [7:0] w,
                                        input logic [15:0] acc);
    if (md) return r2h(h2r(acc) + h2r(a) * f4(w[3:0]));
    return r2h(h2r(acc) + h2r(a) * i8(w));
  endfunction

  logic [15:0] p1_1, p1_2, p2_1, p2_2, p3_1, p3_2;
  always @(posedge clk) begin
    if (reset) begin
      p1_1 <= 16'h0; p1_2 <= 16'h0; p2_1 <= 16'h0;
      p2_2 <= 16'h0; p3_1 <= 16'h0; p3_2 <= 16'h0;
    end else begin
      p1_1 <= lane1(fma_mode, fma_act, fma_in, fma_acc1);
      p1_2 <= lane2(fma_mode, fma_act, fma_in, fma_acc2);
      p2_1 <= p1_1; p2_2 <= p1_2;
      p3_1 <= p2_1; p3_2 <= p2_2;
    end
  end
  assign fma_acc1_out = p3_1;
  assign fma_acc2_out = p3_2;

  typedef struct {
    logic        md;
    int          n;
    logic [15:0] act;
    logic [7:0]  w;
    int          in_stall;
    int          out_stall;
    int          poke;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  function automatic vec_t mkv(input logic md, input int n, input logic [15:0] act, input logic [7:0] w,
                               input int is, input int os, input int poke,
                               input logic [15:0] e1, input logic [15:0] e2);
    vec_t v;
    v.md = md; v.n = n; v.act = act; v.w = w; v.in_stall = is; v.out_stall = os;
    v.poke = poke; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int accepted = 0, ir_cycles = 0, busy_cycles = 0, first_valid = -1, prev_ir = -1;
    int stall_left, ostall_left, n;
    bit done = 0;
    logic [15:0] res1 = 16'h0, res2 = 16'h0;
    real e1, e2;
    stall_left  = v.in_stall;
    ostall_left = v.out_stall;
    @(negedge clk);
    start = 1'b1; len = LEN_W'(v.n); mode = v.md;
    in_act = v.act; in_w = v.w; in_valid = 1'b0; out_ready = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      start = 1'b0;
      if (n == v.poke) begin
        start = 1'b1; len = LEN_W'(5); mode = !v.md;
      end
      if (busy) busy_cycles++;
      check({tag, " fma_act"}, 32'(fma_act), in_ready ? 32'(v.act) : 32'h0);
      check({tag, " fma_in"}, 32'(fma_in), in_ready ? 32'(v.w) : 32'h0);
      if (in_ready) begin
        ir_cycles++;
        if (stall_left > 0) begin
          in_valid = 1'b0;
          stall_left--;
        end else begin
          in_valid = 1'b1;
          accepted++;
          if (prev_ir >= 0 && v.in_stall == 0) check({tag, " issue gap"}, 32'(n - prev_ir), 32'(FMA_LAT + 1));
          prev_ir = n;
        end
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (first_valid < 0) begin
          first_valid = n;
          check({tag, " fma_mode"}, 32'(fma_mode), 32'(v.md));
        end
        check({tag, " out_acc1"}, 32'(out_acc1), 32'(v.exp1));
        check({tag, " out_acc2"}, 32'(out_acc2), 32'(v.exp2));
        res1 = out_acc1;
        res2 = out_acc2;
        if (ostall_left > 0) begin
          out_ready = 1'b0;
          ostall_left--;
        end else begin
          out_ready = 1'b1;
          done = 1;
        end
      end else begin
        out_ready = 1'b0;
      end
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s timeout no result after %0d cycles", tag, n);
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
    check({tag, " idle busy"}, 32'(busy), 32'h0);
    check({tag, " idle out_valid"}, 32'(out_valid), 32'h0);
    check({tag, " accepted"}, 32'(accepted), 32'(v.n));
    check({tag, " in_ready cycles"}, 32'(ir_cycles), 32'(v.n + v.in_stall));
    check({tag, " latency"}, 32'(first_valid), 32'((FMA_LAT + 1) * v.n + v.in_stall));
    check({tag, " busy cycles"}, 32'(busy_cycles), 32'((FMA_LAT + 1) * v.n + 1 + v.in_stall + v.out_stall));
`ifdef FMA_SEQ_PERF_EN
    check({tag, " perf_cycles"}, perf_cycles, 32'(busy_cycles));
`endif
    e1 = v.md ? real'(v.n) * h2r(v.act) * f4(v.w[7:4]) : 0.0;
    e2 = real'(v.n) * h2r(v.act) * (v.md ? f4(v.w[3:0]) : i8(v.w));
    check({tag, " golden acc1"}, 32'(res1), 32'(r2h(e1)));
    check({tag, " golden acc2"}, 32'(res2), 32'(r2h(e2)));
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = mkv(1'b0, 3, 16'h3C00, 8'h02, 0, 0, -1, 16'h0000, 16'h4600);
    vecs[1] = mkv(1'b1, 2, 16'h4000, 8'h24, 0, 0, -1, 16'h4400, 16'h4800);
    vecs[2] = mkv(1'b0, 0, 16'h3C00, 8'h02, 0, 0, -1, 16'h0000, 16'h0000);
    vecs[3] = mkv(1'b0, 3, 16'h3C00, 8'h02, 5, 7, -1, 16'h0000, 16'h4600);
    vecs[4] = mkv(1'b1, 3, 16'hBC00, 8'h31, 0, 0, -1, 16'hC480, 16'hBE00);
    vecs[5] = mkv(1'b0, 2, 16'h4000, 8'hFD, 0, 0, -1, 16'h0000, 16'hCA00);
    vecs[6] = mkv(1'b1, 2, 16'h4000, 8'h24, 0, 0, 2, 16'h4400, 16'h4800);

    reset = 1'b1; start = 1'b0; len = '0; mode = 1'b0;
    in_valid = 1'b0; in_act = 16'h0; in_w = 8'h0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset fma_mode", 32'(fma_mode), 32'h0);
    check("reset fma_acc1", 32'(fma_acc1), 32'h0);
    check("reset out_acc2", 32'(out_acc2), 32'h0);
`ifdef FMA_SEQ_PERF_EN
    check("reset perf_cycles", perf_cycles, 32'h0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_job(vecs[i], $sformatf("v%0d", i));

    // reset during the WAIT of element 2 of 4, then a fresh single-element job
    begin
      int acc_cnt = 0;
      int k = 0;
      @(negedge clk);
      start = 1'b1; len = LEN_W'(4); mode = 1'b0; in_act = 16'h3C00; in_w = 8'h02;
      while (acc_cnt < 2 && k < 50) begin
        @(negedge clk);
        start = 1'b0;
        in_valid = in_ready;
        if (in_ready) acc_cnt++;
        k++;
      end
      check("midreset accepted", 32'(acc_cnt), 32'h2);
      @(negedge clk);
      in_valid = 1'b0;
      check("midreset in_wait busy", 32'(busy), 32'h1);
      check("midreset in_wait in_ready", 32'(in_ready), 32'h0);
      reset = 1'b1;
      @(negedge clk);
      check("midreset busy", 32'(busy), 32'h0);
      check("midreset out_valid", 32'(out_valid), 32'h0);
      check("midreset fma_acc2", 32'(fma_acc2), 32'h0);
      reset = 1'b0;
      run_job(mkv(1'b0, 1, 16'h3C00, 8'h05, 0, 0, -1, 16'h0000, 16'h4500), "fresh");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fma_dot_sequencer.md
Name: fma_dot_sequencer

Overview:
- Upstream control stage for dualFMA. Runs one length-`len` dot product, one element at a time, over a valid/ready activation/weight stream.
- Drives dualFMA's act/in/mode/acc1/acc2 inputs and feeds its acc outputs back as the next accumulator values. dualFMA registers its outputs, so the sequencer stalls for that pipeline latency before the next issue.
- Presents the final fp16 pair on a valid/ready result port.

Parameters:
- FMA_LAT, 3, cycles from issue cycle to the cycle dualFMA acc outputs hold that element's result.
- LEN_W, 10, width of the element-count input.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin job; sampled only in IDLE
- len  in  LEN_W  element count, latched at start
- mode  in  1  0: int8 weights, 1: 2xfp4 weights; latched at start
- busy  out  1  high in any state except IDLE
- in_valid  in  1  element stream valid
- in_ready  out  1  element stream ready
- in_act  in  16  fp16 activation
- in_w  in  8  weight byte (int8, or {fp4 for acc1, fp4 for acc2})
- fma_act  out  16  to dualFMA act
- fma_in  out  8  to dualFMA in
- fma_mode  out  1  to dualFMA mode
- fma_acc1  out  16  to dualFMA acc1
- fma_acc2  out  16  to dualFMA acc2
- fma_acc1_out  in  16  from dualFMA acc1_out
- fma_acc2_out  in  16  from dualFMA acc2_out
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- out_acc1  out  16  final acc1; 0 in mode 0
- out_acc2  out  16  final acc2

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, DONE.
- Reset: state to IDLE. busy, in_ready, out_valid = 0. Accumulator regs, remaining counter, wait counter, and latched mode = 0.
- IDLE, start=1:
  - Latch len and mode; clear both accumulator regs to 0x0000.
  - If len==0, go to DONE (result 0/0). Otherwise load remaining=len and go to ISSUE.
- ISSUE:
  - in_ready=1. fma_act=in_act and fma_in=in_w, combinational (dualFMA samples them at this edge).
  - fma_acc1/fma_acc2 = accumulator regs. fma_mode = latched mode.
  - On in_valid&&in_ready: load wcnt=0 and go to WAIT.
- WAIT:
  - in_ready=0. fma_act and fma_in forced to 0, so bubbles are harmless. wcnt increments each cycle.
  - When wcnt==FMA_LAT-1: capture fma_acc1_out/fma_acc2_out into the accumulator regs and decrement remaining.
  - Then go to DONE if remaining reaches 0, else to ISSUE.
  - With FMA_LAT=3, issue period is 4 cycles per element.
- DONE:
  - out_valid=1; out_acc1/out_acc2 come from the accumulator regs and are stable while stalled.
  - out_acc1 is forced to 0 when the latched mode==0.
  - On out_ready: go to IDLE (out_valid falls the next cycle).
- Outside ISSUE: fma_act/fma_in = 0, and fma_mode holds the latched mode.
- start asserted outside IDLE is ignored. len/mode changes after start are ignored.
- in_valid without in_ready: no data consumed; the source must hold its data.
- Reset mid-job: immediate return to IDLE with no out_valid. dualFMA is reset by the same signal, so no stale result is captured.
- Counter widths: remaining is LEN_W bits. wcnt is ceil(log2(FMA_LAT)) bits, minimum 1.

Optional Feature:
- Macro FMA_SEQ_PERF_EN.
- Defined: adds output perf_cycles[31:0].
  - Cleared on an accepted start; increments every cycle busy=1.
  - Holds its value in IDLE until the next start; saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: the port and counter are absent; no other behaviour change.

Test Plan:
- Mode 0, len=3, in_act=0x3C00 (1.0), in_w=0x02 each element -> out_acc2=0x4600 (6.0), out_acc1=0. out_valid first rises 12 cycles after the first in_ready edge. in_ready pulses exactly once per 4 cycles.
- Mode 1, len=2, in_act=0x4000 (2.0), in_w=0x24 (fp4 e2m1: 1.0 and 2.0) -> out_acc1=0x4400 (4.0), out_acc2=0x4800 (8.0). Results also checked against a dualFMA golden model.
- len=0 with start -> DONE the next cycle; out_acc1=out_acc2=0x0000; no in_ready pulse; busy high for exactly 1 cycle when out_ready=1.
- Back-pressure: hold in_valid=0 for 5 cycles in ISSUE, and hold out_ready=0 for 7 cycles in DONE -> no element lost, out_acc stable while stalled, same result as the no-stall run.
- Reset asserted during WAIT of element 2 of 4 -> IDLE next cycle. A fresh job started afterwards (mode 0, len=1, act=0x3C00, w=0x05) -> out_acc2=0x4500 (5.0), no carry-over.
- start pulsed while busy -> ignored; len/latched mode unchanged. With FMA_SEQ_PERF_EN: perf_cycles equals the observed busy-cycle count (13 for the len=3 case).
